alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Iterative multiply/divide unit in the multi-cycle CPU's execute stage, running alongside the ALU. Operand A comes from the register-file A latch; operand B is the same ALU-B source selected between sign-extended immediate and register data. A radix-2 shift-add/subtract engine performs 32 iterations and writes the 64-bit result into the HI/LO registers. The control FSM holds the instruction in the execute state until `done`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- `opa`  in  WIDTH  operand A: multiplicand or dividend.
- `opb`  in  WIDTH  operand B: multiplier or divisor, taken from the ALU-B source select.
- `cancel`  in  1  synchronous abort, used on pipeline flush or exception.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when `hi`/`lo` have just been updated.
- `hi`  out  WIDTH  multiply: upper product word. Divide: remainder.
- `lo`  out  WIDTH  multiply: lower product word. Divide: quotient.

## Operation
- FSM states: IDLE, CALC, SIGN.
  - IDLE→CALC on `start && !cancel`.
  - CALC→SIGN after 32 iterations.
  - SIGN→IDLE always.
  - Any state→IDLE on `cancel`.
- Start edge (IDLE, `start` high):
  - Latch `op`.
  - Latch magnitudes |opa| and |opb|. Signed ops take the two's-complement absolute value. Unsigned ops take the operand unchanged.
  - Record the result signs:
    - Product sign = signA ^ signB.
    - Quotient sign = signA ^ signB.
    - Remainder sign = signA.
  - Clear the iteration counter.
- CALC, multiply: one shift-add per cycle into a 65-bit accumulator {carry, P_hi, P_lo}. If P_lo[0] is set, add the multiplicand to P_hi. Then shift the whole accumulator right by 1.
- CALC, divide: restoring division, one step per cycle, on a 33-bit partial remainder.
  - Shift {R, Q} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and set Q[0]=1.
- SIGN:
  - Negate the 64-bit product, or the quotient/remainder individually, per the recorded signs.
  - Write `hi`/`lo`.
  - Pulse `done`.
- Divide by zero (opb==0), natural restoring result, no trap: `lo`=0xFFFFFFFF, `hi`=opa. Same for signed and unsigned, with no sign fix applied.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `start` while `busy`: ignored, with no queueing.
- `cancel` with `start` in the same cycle: `cancel` wins; the request is dropped.
- `cancel` mid-operation:
  - Return to IDLE next edge.
  - `busy` falls.
  - No `done`.
  - `hi`/`lo` retain their previous values.
- `hi`/`lo` hold their value until the next completed operation.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately, asynchronously.
- Edge E0 samples `start`. `busy`=1 from after E0.
- Edges E1..E32 are the CALC iterations. E33 is SIGN.
- After E33: `done`=1 for exactly one cycle, `busy`=0, `hi`/`lo` valid.
- Latency is fixed at 33 cycles from start sample to `done` for every op and every operand value, divide-by-zero included.
- Back-to-back operation: a new `start` is accepted in the cycle `done` is high, because the FSM is already in IDLE.
- Operands need only be valid in the start cycle; later changes have no effect.

## Structure
- Package `muldiv_pkg` holds:
  - the op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - the state enum;
  - the constant `ITER`=32.
- Sub-module `muldiv_step`: the combinational single-iteration datapath, which performs either the conditional add+shift (multiply) or the shift+trial-subtract (divide). The top level holds the FSM, counter, sign logic and HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` exactly 33 cycles after start; `busy` high for exactly 33 cycles.
- MULT −3 × 7 (0xFFFFFFFD × 7): `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV −7 / 2: `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- DIVU 100 / 0: `lo`=0xFFFFFFFF, `hi`=100.
- DIV 0x80000000 / −1: `lo`=0x80000000, `hi`=0.
- Control corner cases:
  - Pulse `start` again at cycle 10: it is ignored, and only one `done` pulse occurs.
  - `cancel` at cycle 20: no `done`, `hi`/`lo` unchanged.
  - Drop `rst_n` mid-CALC: all outputs return to 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds op codes, FSM state enum and the iteration count.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: conditional add + right shift (multiply) or left shift + trial subtract (divide).
// Purely combinational, zero latency; no flow control.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    // The carry bit of the accumulator is always clear between steps, so it folds into the adder.
    assign w_sum    = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
    assign w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_b};

    always_comb begin
        o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh, i_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing a 64-bit result into HI/LO.
// Fixed 33-cycle latency from start sample to done; start while busy is dropped, cancel aborts.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_div;
    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [2*WIDTH:0]   w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    assign w_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_sa     = w_signed & opa[WIDTH-1];
    assign w_sb     = w_signed & opb[WIDTH-1];
    assign w_ma     = w_sa ? -opa : opa;
    assign w_mb     = w_sb ? -opb : opb;
    assign w_prod   = r_acc[2*WIDTH-1:0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_b   (r_b),
        .o_acc (w_acc_nxt)
    );

    always_comb begin
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_neg_hi) w_hi_fix = -w_prod[2*WIDTH-1:WIDTH];
            if (r_neg_lo) w_lo_fix = -w_prod[WIDTH-1:0];
        end else if (r_neg_lo) begin
            {w_hi_fix, w_lo_fix} = -w_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_acc    <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (cancel) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state  <= ST_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_div    <= w_div;
                            // Divide by zero keeps the all-ones quotient; remainder fix restores opa.
                            r_neg_lo <= (w_sa ^ w_sb) & ~(w_div && (opb == '0));
                            r_neg_hi <= w_sa;
                            r_acc    <= {{(WIDTH+1){1'b0}}, (w_div ? w_ma : w_mb)};
                            r_b      <= w_div ? w_mb : w_ma;
                        end
                    end
                    ST_CALC: begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_state <= ST_SIGN;
                    end
                    ST_SIGN: begin
                        r_hi    <= w_hi_fix;
                        r_lo    <= w_lo_fix;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: arithmetic vectors, latency, and control corner cases.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    alu_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: return sa * sb;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Drive a one-cycle start; returns #1 after the sampling edge with operands scrambled.
    task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        if (push) sb_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int bcyc, output bit got);
        cyc = 0; got = 1'b0;
        bcyc = busy ? 1 : 0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
            else if (busy) bcyc++;
        end
    endtask

    task automatic idle_cycles(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
    endtask

    task automatic run_vector(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] exp);
        int cyc, bcyc; bit got; logic [63:0] e;
        kick(o, a, b, exp, 1'b1);
        wait_done(cyc, bcyc, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", name, cyc);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if ({hi, lo} !== e) begin
                errors++;
                $display("FAIL %s_result: op=%0d a=%h b=%h got hi=%h lo=%h, required hi=%h lo=%h",
                         name, o, a, b, hi, lo, e[63:32], e[31:0]);
            end
            checks++;
            if (cyc !== 33 || bcyc !== 33 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_timing: done_at=%0d busy_cycles=%0d busy_at_done=%b, required 33/33/0",
                         name, cyc, bcyc, busy);
            end
        end
    endtask

    task automatic test_mul();
        logic [1:0] o; logic [31:0] a, b;
        run_vector("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_vector("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_vector("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_vector("multu_zero", 2'b00, 32'd0, 32'h0001_2345, 64'd0);
        for (int i = 0; i < 4; i++) begin
            o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
            run_vector("mul_rand", o, a, b, model(o, a, b));
        end
    endtask

    task automatic test_div();
        logic [1:0] o; logic [31:0] a, b;
        run_vector("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_vector("divu_by0", 2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        run_vector("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_vector("div_neg_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        run_vector("divu_small", 2'b10, 32'd7, 32'd9, 64'h0000_0007_0000_0000);
        run_vector("div_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        for (int i = 0; i < 4; i++) begin
            o = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 31);
            run_vector("div_rand", o, a, b, model(o, a, b));
        end
    endtask

    task automatic test_restart_ignored();
        int cyc, bcyc, dones; bit got; logic [63:0] e;
        kick(2'b00, 32'd1234, 32'd5678, 64'd7006652, 1'b1);
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        @(negedge clk); start = 1'b1; op = 2'b10; opa = 32'd99; opb = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(cyc, bcyc, got);
        e = sb_q.pop_front();
        checks++;
        if (!got || {hi, lo} !== e || (cyc + 10) !== 33) begin
            errors++;
            $display("FAIL restart_ignored: got=%b done_at=%0d hi=%h lo=%h, required done at 33 hi=%h lo=%h",
                     got, cyc + 10, hi, lo, e[63:32], e[31:0]);
        end
        idle_cycles(40, dones);
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_single_done: extra_dones=%0d busy=%b, required 0 and 0", dones, busy);
        end
    endtask

    task automatic test_cancel();
        int dones; logic [63:0] prev;
        prev = {hi, lo};
        kick(2'b01, 32'h1234_5678, 32'h0BAD_F00D, 64'd0, 1'b0);
        for (int i = 0; i < 19; i++) begin @(posedge clk); #1; end
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy: busy=%b, required 0", busy);
        end
        idle_cycles(40, dones);
        checks++;
        if (dones !== 0 || {hi, lo} !== prev) begin
            errors++;
            $display("FAIL cancel_hold: dones=%0d hi=%h lo=%h, required 0 dones hi=%h lo=%h",
                     dones, hi, lo, prev[63:32], prev[31:0]);
        end
        @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'b00; opa = 32'd5; opb = 32'd6;
        @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_with_start_busy: busy=%b, required 0", busy);
        end
        idle_cycles(40, dones);
        checks++;
        if (dones !== 0 || {hi, lo} !== prev) begin
            errors++;
            $display("FAIL cancel_with_start_hold: dones=%0d hi=%h lo=%h, required 0 dones hi=%h lo=%h",
                     dones, hi, lo, prev[63:32], prev[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc; bit got; logic [63:0] e;
        kick(2'b10, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 1'b1);
        wait_done(cyc, bcyc, got);
        e = sb_q.pop_front();
        checks++;
        if (!got || done !== 1'b1 || {hi, lo} !== e) begin
            errors++;
            $display("FAIL b2b_first: got=%b done=%b hi=%h lo=%h, required done hi=%h lo=%h",
                     got, done, hi, lo, e[63:32], e[31:0]);
        end
        kick(2'b01, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_done(cyc, bcyc, got);
        e = sb_q.pop_front();
        checks++;
        if (!got || cyc !== 33 || {hi, lo} !== e) begin
            errors++;
            $display("FAIL b2b_second: got=%b done_at=%0d hi=%h lo=%h, required 33 hi=%h lo=%h",
                     got, cyc, hi, lo, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        kick(2'b00, 32'd77, 32'd88, 64'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        @(negedge clk); rst_n = 1'b1;
        idle_cycles(40, dones);
        checks++;
        if (dones !== 0 || {busy, hi, lo} !== 65'b0) begin
            errors++;
            $display("FAIL async_reset_after: dones=%0d busy=%b hi=%h lo=%h, required all zero",
                     dones, busy, hi, lo);
        end
        run_vector("post_reset", 2'b00, 32'd77, 32'd88, 64'd6776);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_restart_ignored();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
